calc_ctrl: RTL and testbench

Sequencing controller for the four-function calculator. Consumes debounced key events (`key_flag` pulse plus 4-bit `key_code`) from the matrix-keypad scanner. Builds decimal operands, latches operators, and runs add/subtract/multiply/divide with left-to-right chaining. Presents a signed result magnitude to the display path.

---
 rtl/calc_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_calc_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl.sv
// ============================================================================
// Module   : calc_ctrl
// Brief    : Key-driven sequencing controller for a four-function calculator.
//            Builds decimal operands from keypad digits, latches operators,
//            and evaluates left-to-right chains of + - x (and / when built in).
// Options  : CALC_DIV_EN - include the restoring divider for the divide key.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_ctrl #(
  parameter int MAX_DIGITS = 4,
  parameter int RW         = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_flag_i,
  input  logic [3:0]    key_code_i,
  output logic [RW-1:0] disp_mag_o,
  output logic          disp_neg_o,
  output logic          err_o,
  output logic          busy_o,
  output logic          res_valid_o
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [RW-1:0] mag_of(input logic signed [RW-1:0] v);
    if (v[RW-1]) return $unsigned(-v);
    else         return $unsigned(v);
  endfunction

  localparam longint        ENT_MAX = pow10(MAX_DIGITS) - 1;
  localparam longint        LIMIT   = pow10(2 * MAX_DIGITS) - 1;
  localparam int            EW      = $clog2(ENT_MAX + 1);
  localparam int            PW      = RW + EW;
  localparam int            DW      = $clog2(MAX_DIGITS + 1);
  localparam logic [PW-1:0] LIMIT_P = PW'(LIMIT);

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_OP   = 3'd1,
    ST_B    = 3'd2,
    ST_EXEC = 3'd3,
    ST_RES  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  state_t               state_q, state_d;
  logic [EW-1:0]        ent_q, ent_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic signed [RW-1:0] acc_q, acc_d;
  op_t                  op_q, op_d;
  logic                 nxt_vld_q, nxt_vld_d;
  op_t                  nxt_op_q, nxt_op_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 rv_q, rv_d;
  logic [RW-1:0]        disp_mag_q, disp_mag_d;
  logic                 disp_neg_q, disp_neg_d;

  logic                 key_dig, key_opr, key_eq, key_clr;
  op_t                  key_op;
  logic [EW-1:0]        ent_app;

  logic signed [PW-1:0] acc_x, ent_x, alu_res;
  logic [PW-1:0]        alu_mag;
  logic                 alu_ovf;

  logic                 fin, fail;
  logic signed [RW-1:0] fin_val;

`ifdef CALC_DIV_EN
  localparam int        CW = $clog2(RW);
  logic [RW-1:0]        dq_q, dq_d;
  logic [EW-1:0]        rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 dneg_q, dneg_d;
  logic [EW:0]          rem_sh;
  logic                 div_ge;
  logic [EW-1:0]        rem_nx;
  logic [RW-1:0]        dq_nx;
  logic signed [RW-1:0] div_res;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh  = {rem_q, dq_q[RW-1]};
    div_ge  = (rem_sh >= {1'b0, ent_q});
    rem_nx  = div_ge ? EW'(rem_sh - {1'b0, ent_q}) : rem_sh[EW-1:0];
    dq_nx   = {dq_q[RW-2:0], div_ge};
    div_res = dneg_q ? -$signed(dq_nx) : $signed(dq_nx);
  end
`endif

  // Classify the incoming key; divide counts as an operator only when built in
  always_comb begin
    key_dig = key_flag_i && (key_code_i <= 4'd9);
`ifdef CALC_DIV_EN
    key_opr = key_flag_i && (key_code_i >= 4'd10) && (key_code_i <= 4'd13);
`else
    key_opr = key_flag_i && (key_code_i >= 4'd10) && (key_code_i <= 4'd12);
`endif
    key_eq  = key_flag_i && (key_code_i == 4'd14);
    key_clr = key_flag_i && (key_code_i == 4'd15);
    case (key_code_i)
      4'd11:   key_op = OP_SUB;
      4'd12:   key_op = OP_MUL;
      4'd13:   key_op = OP_DIV;
      default: key_op = OP_ADD;
    endcase
    ent_app = EW'(32'(ent_q) * 32'd10 + 32'(key_code_i));
  end

  // Single-cycle add/subtract/multiply at full precision with range check
  always_comb begin
    acc_x = PW'(acc_q);
    ent_x = $signed(PW'(ent_q));
    case (op_q)
      OP_SUB:  alu_res = acc_x - ent_x;
      OP_MUL:  alu_res = acc_x * ent_x;
      default: alu_res = acc_x + ent_x;
    endcase
    alu_mag = alu_res[PW-1] ? $unsigned(-alu_res) : $unsigned(alu_res);
    alu_ovf = (alu_mag > LIMIT_P);
  end

  // Next-state logic: key handling per state, execution, and display selection
  always_comb begin
    state_d    = state_q;
    ent_d      = ent_q;
    dcnt_d     = dcnt_q;
    acc_d      = acc_q;
    op_d       = op_q;
    nxt_vld_d  = nxt_vld_q;
    nxt_op_d   = nxt_op_q;
    err_d      = err_q;
    rv_d       = 1'b0;
    disp_mag_d = disp_mag_q;
    disp_neg_d = disp_neg_q;
    fin        = 1'b0;
    fail       = 1'b0;
    fin_val    = '0;
`ifdef CALC_DIV_EN
    dq_d       = dq_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    dneg_d     = dneg_q;
`endif

    if (state_q == ST_EXEC) begin
      // Keys are dropped entirely while executing
`ifdef CALC_DIV_EN
      if (op_q == OP_DIV) begin
        if ((cnt_q == '0) && (ent_q == '0)) begin
          fail = 1'b1;
        end else begin
          dq_d  = dq_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(RW - 1)) begin
            fin     = 1'b1;
            fin_val = div_res;
          end
        end
      end else
`endif
      begin
        if (alu_ovf) begin
          fail = 1'b1;
        end else begin
          fin     = 1'b1;
          fin_val = RW'(alu_res);
        end
      end

      if (fail) begin
        err_d   = 1'b1;
        state_d = ST_ERR;
      end else if (fin) begin
        acc_d = fin_val;
        rv_d  = 1'b1;
        if (nxt_vld_q) begin
          op_d      = nxt_op_q;
          nxt_vld_d = 1'b0;
          state_d   = ST_OP;
        end else begin
          state_d = ST_RES;
        end
      end
    end else if (key_clr) begin
      ent_d     = '0;
      dcnt_d    = '0;
      acc_d     = '0;
      op_d      = OP_ADD;
      nxt_vld_d = 1'b0;
      nxt_op_d  = OP_ADD;
      err_d     = 1'b0;
      state_d   = ST_A;
    end else begin
      case (state_q)
        ST_A, ST_B: begin
          if (key_dig) begin
            if (dcnt_q < DW'(MAX_DIGITS)) begin
              ent_d  = ent_app;
              dcnt_d = dcnt_q + DW'(1);
            end
          end else if (state_q == ST_A) begin
            if (key_opr) begin
              acc_d   = $signed(RW'(ent_q));
              op_d    = key_op;
              state_d = ST_OP;
            end else if (key_eq) begin
              acc_d   = $signed(RW'(ent_q));
              state_d = ST_RES;
            end
          end else if (key_opr || key_eq) begin
            // Second operand complete: remember any chained operator and run
            nxt_vld_d = key_opr;
            nxt_op_d  = key_op;
            state_d   = ST_EXEC;
`ifdef CALC_DIV_EN
            dq_d   = mag_of(acc_q);
            rem_d  = '0;
            cnt_d  = '0;
            dneg_d = acc_q[RW-1];
`endif
          end
        end
        ST_OP: begin
          if (key_dig) begin
            ent_d   = EW'(key_code_i);
            dcnt_d  = DW'(1);
            state_d = ST_B;
          end else if (key_opr) begin
            op_d = key_op;
          end
        end
        ST_RES: begin
          if (key_dig) begin
            // A fresh number discards the previous result
            ent_d   = EW'(key_code_i);
            dcnt_d  = DW'(1);
            acc_d   = '0;
            state_d = ST_A;
          end else if (key_opr) begin
            op_d    = key_op;
            state_d = ST_OP;
          end
        end
        default: ;
      endcase
    end

    case (state_d)
      ST_A, ST_B: begin
        disp_mag_d = RW'(ent_d);
        disp_neg_d = 1'b0;
      end
      ST_OP, ST_RES: begin
        disp_mag_d = mag_of(acc_d);
        disp_neg_d = acc_d[RW-1];
      end
      ST_ERR: begin
        disp_mag_d = '0;
        disp_neg_d = 1'b0;
      end
      default: ;
    endcase

    busy_d = (state_d == ST_EXEC);
  end

  // State and output registers; reset aborts any computation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_A;
      ent_q      <= '0;
      dcnt_q     <= '0;
      acc_q      <= '0;
      op_q       <= OP_ADD;
      nxt_vld_q  <= 1'b0;
      nxt_op_q   <= OP_ADD;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      disp_mag_q <= '0;
      disp_neg_q <= 1'b0;
`ifdef CALC_DIV_EN
      dq_q       <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      dneg_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ent_q      <= ent_d;
      dcnt_q     <= dcnt_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      nxt_vld_q  <= nxt_vld_d;
      nxt_op_q   <= nxt_op_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      disp_mag_q <= disp_mag_d;
      disp_neg_q <= disp_neg_d;
`ifdef CALC_DIV_EN
      dq_q       <= dq_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      dneg_q     <= dneg_d;
`endif
    end
  end

  assign disp_mag_o  = disp_mag_q;
  assign disp_neg_o  = disp_neg_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign res_valid_o = rv_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_ctrl.sv
// ============================================================================
// Module   : tb_calc_ctrl
// Brief    : Self-checking bench for calc_ctrl. A key-level calculator model
//            predicts every output each cycle; directed sequences pin the
//            model to hand-computed results, then random key traffic follows.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_ctrl;

  localparam int     RW    = 28;
  localparam int     MAXD  = 4;
  localparam longint LIMIT = 64'd99999999;
`ifdef CALC_DIV_EN
  localparam bit     DIV_EN = 1'b1;
`else
  localparam bit     DIV_EN = 1'b0;
`endif
  localparam int M_A = 0, M_OP = 1, M_B = 2, M_EXEC = 3, M_RES = 4, M_ERR = 5;

  logic          clk, rst_n, key_flag_i;
  logic [3:0]    key_code_i;
  logic [RW-1:0] disp_mag_o;
  logic          disp_neg_o, err_o, busy_o, res_valid_o;

  calc_ctrl #(.MAX_DIGITS(MAXD), .RW(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_flag_i (key_flag_i),
    .key_code_i (key_code_i),
    .disp_mag_o (disp_mag_o),
    .disp_neg_o (disp_neg_o),
    .err_o      (err_o),
    .busy_o     (busy_o),
    .res_valid_o(res_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, busy_cnt = 0, rv_cnt = 0;

  // Calculator model: operators are kept as their key codes (10..13)
  int     m_mode, m_dcnt, m_op, m_nxt, m_left;
  longint m_ent, m_acc, m_pres;
  bit     m_perr, m_err, m_rv;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_A; m_ent = 0; m_dcnt = 0; m_acc = 0; m_op = 10; m_nxt = -1;
    m_err = 0; m_rv = 0; m_left = 0; m_pres = 0; m_perr = 0;
  endtask

  task automatic start_exec(input int nxt);
    m_nxt  = nxt;
    m_perr = 0;
    m_left = 1;
    case (m_op)
      10: m_pres = m_acc + m_ent;
      11: m_pres = m_acc - m_ent;
      12: m_pres = m_acc * m_ent;
      default: begin
        if (m_ent == 0) begin
          m_perr = 1;
          m_pres = 0;
        end else begin
          m_pres = m_acc / m_ent;
          m_left = RW;
        end
      end
    endcase
    if (m_pres > LIMIT || m_pres < -LIMIT) m_perr = 1;
    m_mode = M_EXEC;
  endtask

  task automatic apply_key(input int kc);
    bit dig, opr, eq;
    dig = (kc <= 9);
    opr = (kc >= 10) && (kc <= (DIV_EN ? 13 : 12));
    eq  = (kc == 14);
    if (kc == 15) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_A, M_B: begin
        if (dig) begin
          if (m_dcnt < MAXD) begin
            m_ent  = m_ent * 10 + kc;
            m_dcnt = m_dcnt + 1;
          end
        end else if (m_mode == M_A && opr) begin
          m_acc = m_ent; m_op = kc; m_mode = M_OP;
        end else if (m_mode == M_A && eq) begin
          m_acc = m_ent; m_mode = M_RES;
        end else if (m_mode == M_B && opr) begin
          start_exec(kc);
        end else if (m_mode == M_B && eq) begin
          start_exec(-1);
        end
      end
      M_OP: begin
        if (dig) begin
          m_ent = kc; m_dcnt = 1; m_mode = M_B;
        end else if (opr) m_op = kc;
      end
      M_RES: begin
        if (dig) begin
          m_ent = kc; m_dcnt = 1; m_acc = 0; m_mode = M_A;
        end else if (opr) begin
          m_op = kc; m_mode = M_OP;
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_edge(input bit kf, input int kc);
    m_rv = 0;
    if (m_mode == M_EXEC) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_perr) begin
          m_err = 1; m_mode = M_ERR;
        end else begin
          m_acc = m_pres; m_rv = 1;
          if (m_nxt >= 0) begin
            m_op = m_nxt; m_nxt = -1; m_mode = M_OP;
          end else m_mode = M_RES;
        end
      end
    end else if (kf) begin
      apply_key(kc);
    end
  endtask

  task automatic compare_all();
    longint shown, mag;
    case (m_mode)
      M_A, M_B:     shown = m_ent;
      M_OP, M_RES:  shown = m_acc;
      default:      shown = 0;
    endcase
    mag = (shown < 0) ? -shown : shown;
    if (m_mode != M_EXEC) begin
      chk("disp_mag", longint'(disp_mag_o), mag);
      chk("disp_neg", longint'(disp_neg_o), longint'(shown < 0));
    end
    chk("err", longint'(err_o), longint'(m_err));
    chk("busy", longint'(busy_o), longint'(m_mode == M_EXEC));
    chk("res_valid", longint'(res_valid_o), longint'(m_rv));
    if (busy_o) busy_cnt++;
    if (res_valid_o) rv_cnt++;
  endtask

  task automatic cyc(input bit kf, input int kc);
    key_flag_i = kf;
    key_code_i = 4'(kc);
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(kf, kc);
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input int c);
    cyc(1'b1, c);
    for (int i = 0; i < 64 && busy_o; i++) cyc(1'b0, 0);
    if (busy_o) chk("exec_timeout", longint'(busy_o), 0);
  endtask

  int b0, r0;

  initial begin
    rst_n = 1'b0; key_flag_i = 1'b0; key_code_i = 4'd0;
    model_reset();
    repeat (3) cyc(1'b0, 0);
    chk("reset_mag", longint'(disp_mag_o), 0);
    chk("reset_busy", longint'(busy_o), 0);
    rst_n = 1'b1;

    // 12 + 34 = 46
    b0 = busy_cnt; r0 = rv_cnt;
    press(1); press(2); press(10); press(3); press(4); press(14);
    chk("tp1_mag", longint'(disp_mag_o), 46);
    chk("tp1_neg", longint'(disp_neg_o), 0);
    chk("tp1_busy_cycles", longint'(busy_cnt - b0), 1);
    chk("tp1_rv_pulses", longint'(rv_cnt - r0), 1);

    // 5 - 9 = -4, then -4 + 6 = +2
    press(15); press(5); press(11); press(9); press(14);
    chk("tp2_mag", longint'(disp_mag_o), 4);
    chk("tp2_neg", longint'(disp_neg_o), 1);
    press(10); press(6); press(14);
    chk("tp2b_mag", longint'(disp_mag_o), 2);
    chk("tp2b_neg", longint'(disp_neg_o), 0);

    // Chaining: 7 x 8 - shows 56, then 6 = gives 50
    press(15); press(7); press(12); press(8); press(11);
    chk("tp3_chain_mag", longint'(disp_mag_o), 56);
    chk("tp3_chain_busy", longint'(busy_o), 0);
    press(6); press(14);
    chk("tp3_mag", longint'(disp_mag_o), 50);

    // Digit limit, big product, overflow, error lock, clear
    press(15); press(1); press(2); press(3); press(4); press(5);
    chk("tp4_digits", longint'(disp_mag_o), 1234);
    press(15);
    for (int i = 0; i < 4; i++) press(9);
    press(12);
    for (int i = 0; i < 4; i++) press(9);
    press(14);
    chk("tp4_product", longint'(disp_mag_o), 99980001);
    press(12); press(2); press(14);
    chk("tp4_ovf_err", longint'(err_o), 1);
    chk("tp4_ovf_mag", longint'(disp_mag_o), 0);
    press(3);
    chk("tp4_err_hold", longint'(err_o), 1);
    press(15);
    chk("tp4_clr_err", longint'(err_o), 0);
    chk("tp4_clr_mag", longint'(disp_mag_o), 0);

`ifdef CALC_DIV_EN
    // 100 / 7 = 14 over RW busy cycles
    b0 = busy_cnt;
    press(1); press(0); press(0); press(13); press(7); press(14);
    chk("div_busy_cycles", longint'(busy_cnt - b0), RW);
    chk("div_mag", longint'(disp_mag_o), 14);
    // Divide by zero caught after one EXEC cycle
    press(15); press(9); press(13); press(0);
    cyc(1'b1, 14);
    chk("dz_busy", longint'(busy_o), 1);
    cyc(1'b0, 0);
    chk("dz_err", longint'(err_o), 1);
    chk("dz_busy_off", longint'(busy_o), 0);
    // Keys during busy (including CLR) are dropped: 84 / 2 = 42
    press(15); press(8); press(4); press(13); press(2);
    cyc(1'b1, 14); cyc(1'b1, 5); cyc(1'b1, 15); cyc(1'b1, 10);
    for (int i = 0; i < 64 && busy_o; i++) cyc(1'b0, 0);
    chk("drop_mag", longint'(disp_mag_o), 42);
    // Reset during the 10th cycle of a division
    press(15); press(1); press(0); press(0); press(13); press(7);
    cyc(1'b1, 14);
    repeat (9) cyc(1'b0, 0);
`else
    // Divide key is not recognised in this build
    press(15); press(8); press(13); press(2);
    chk("nodiv_mag", longint'(disp_mag_o), 82);
    press(15); press(1); press(2);
`endif
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mag", longint'(disp_mag_o), 0);
    chk("rst_busy", longint'(busy_o), 0);
    chk("rst_err", longint'(err_o), 0);
    chk("rst_rv", longint'(res_valid_o), 0);
    #2 rst_n = 1'b1;
    press(2); press(10); press(2); press(14);
    chk("post_rst_mag", longint'(disp_mag_o), 4);

    // Random key traffic, including keys landing during execution
    press(15);
    for (int i = 0; i < 4000; i++) begin
      int r, kc;
      r = $urandom_range(0, 99);
      if (r < 55)      kc = $urandom_range(0, 9);
      else if (r < 75) kc = $urandom_range(10, 13);
      else if (r < 90) kc = 14;
      else             kc = 15;
      cyc(1'($urandom_range(0, 1)), kc);
    end
    for (int i = 0; i < 64 && busy_o; i++) cyc(1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
